// File: rtl/bcd_to_binary_seq.sv
// ----------------------------------------------------------------------------
// bcd_to_binary_seq
//
// Sequential packed-BCD to binary converter. It uses reverse double-dabble:
// each clock it shifts {bcd_sr, bin_sr} right by one bit, then subtracts 3
// from every BCD digit that has become >= 8. After BIN_W iterations, bin_sr
// holds the low BIN_W bits of the decimal value. Any residue left in bcd_sr
// means the value did not fit, which is reported as overflow.
//
// State table
//   state | meaning
//   IDLE  | waiting for start; a start here captures bcd
//   SHIFT | one reverse double-dabble iteration per clock
//   DONE  | single-cycle done pulse, results valid; start ignored
//
// Ports
//   clk     : single clock, rising edge
//   rst     : asynchronous active-high reset
//   start   : conversion request, sampled only in IDLE
//   bcd     : packed BCD operand, digit 0 = bcd[3:0]
//   binary  : registered result, held until the next completion
//   busy    : high whenever the FSM is not in IDLE
//   done    : one-cycle completion pulse
//   err     : an input digit was > 9 (no conversion performed)
//   ovf     : decimal value >= 2**BIN_W, binary holds value mod 2**BIN_W
// ----------------------------------------------------------------------------
module bcd_to_binary_seq #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic [BIN_W-1:0]      binary,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  ovf
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int TOT_W = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [BCD_W-1:0]   bcd_sr;
    logic [BIN_W-1:0]   bin_sr;
    logic [CNT_W-1:0]   cnt;

    logic               bcd_invalid;
    logic [TOT_W-1:0]   shifted;
    logic [BCD_W-1:0]   bcd_next;
    logic [BIN_W-1:0]   bin_next;

    // Flag any digit outside 0..9 on the live input.
    always_comb begin
        bcd_invalid = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd[4*d +: 4] > 4'd9) begin
                bcd_invalid = 1'b1;
            end
        end
    end

    // One iteration: shift the combined register right, then correct each
    // digit independently. A digit >= 8 after the shift means it received a
    // weight-10 bit from the digit above, which is worth 5 rather than 8.
    // Subtracting 3 fixes that. There is no borrow between digits.
    always_comb begin
        shifted  = {bcd_sr, bin_sr} >> 1;
        bcd_next = shifted[TOT_W-1:BIN_W];
        bin_next = shifted[BIN_W-1:0];
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_next[4*d +: 4] >= 4'd8) begin
                bcd_next[4*d +: 4] = bcd_next[4*d +: 4] - 4'd3;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            bcd_sr <= '0;
            bin_sr <= '0;
            cnt    <= '0;
            binary <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (bcd_invalid) begin
                            // Bad digits skip the iterations entirely.
                            state  <= DONE;
                            done   <= 1'b1;
                            err    <= 1'b1;
                            ovf    <= 1'b0;
                            binary <= '0;
                        end else begin
                            state  <= SHIFT;
                            bcd_sr <= bcd;
                            bin_sr <= '0;
                            cnt    <= '0;
                        end
                    end
                end

                SHIFT: begin
                    bcd_sr <= bcd_next;
                    bin_sr <= bin_next;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        binary <= bin_next;
                        // Anything left in the BCD side did not fit in BIN_W bits.
                        ovf    <= |bcd_next;
                        err    <= 1'b0;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
module tb_bcd_to_binary_seq;

    logic        clk;
    logic        rst;
    logic        start14;
    logic        start8;
    logic [15:0] bcd;

    logic [13:0] binary14;
    logic        busy14, done14, err14, ovf14;
    logic [7:0]  binary8;
    logic        busy8, done8, err8, ovf8;

    int tests = 0;
    int fails = 0;

    bcd_to_binary_seq #(.DIGITS(4), .BIN_W(14)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start14),
        .bcd    (bcd),
        .binary (binary14),
        .busy   (busy14),
        .done   (done14),
        .err    (err14),
        .ovf    (ovf14)
    );

    bcd_to_binary_seq #(.DIGITS(4), .BIN_W(8)) dut8 (
        .clk    (clk),
        .rst    (rst),
        .start  (start8),
        .bcd    (bcd),
        .binary (binary8),
        .busy   (busy8),
        .done   (done8),
        .err    (err8),
        .ovf    (ovf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model: decimal value of the BCD word, plain arithmetic.
    function automatic int dec_value(input logic [15:0] v);
        int acc  = 0;
        int mult = 1;
        for (int d = 0; d < 4; d++) begin
            acc  = acc + int'(v[4*d +: 4]) * mult;
            mult = mult * 10;
        end
        return acc;
    endfunction

    function automatic bit has_bad_digit(input logic [15:0] v);
        bit bad = 1'b0;
        for (int d = 0; d < 4; d++) begin
            if (v[4*d +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        for (int d = 0; d < 4; d++) begin
            v[4*d +: 4] = 4'($urandom_range(0, 9));
        end
        return v;
    endfunction

    // Called at a negedge with the selected DUT idle. This task returns at the
    // negedge where done is (or should be) high.
    task automatic run_conv(input bit w8, input logic [15:0] v, input string tag);
        int  w, lat, lat_exp, val, exp_bin;
        bit  bad, exp_ovf, busy_ok;
        w       = w8 ? 8 : 14;
        bad     = has_bad_digit(v);
        val     = bad ? 0 : dec_value(v);
        exp_bin = bad ? 0 : (val % (1 << w));
        exp_ovf = !bad && (val >= (1 << w));
        lat_exp = bad ? 0 : w;

        bcd = v;
        if (w8) start8 = 1'b1; else start14 = 1'b1;
        @(negedge clk);
        start8  = 1'b0;
        start14 = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        while (!(w8 ? done8 : done14) && lat < 40) begin
            if (!(w8 ? busy8 : busy14)) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        check({tag, "/done"},    32'(w8 ? done8 : done14), 32'd1);
        check({tag, "/latency"}, 32'(lat), 32'(lat_exp));
        check({tag, "/busy"},    32'(busy_ok && (w8 ? busy8 : busy14)), 32'd1);
        check({tag, "/binary"},  32'(w8 ? binary8 : binary14), 32'(exp_bin));
        check({tag, "/err"},     32'(w8 ? err8 : err14), 32'(bad));
        check({tag, "/ovf"},     32'(w8 ? ovf8 : ovf14), 32'(exp_ovf));
    endtask

    initial begin
        int          done_seen;
        int          exp_q[$];
        int          exp_v;
        bit          exp_done;

        rst     = 1'b1;
        start14 = 1'b0;
        start8  = 1'b0;
        bcd     = 16'h0000;

        // Check the reset state.
        @(negedge clk);
        check("rst/binary", 32'(binary14), 32'd0);
        check("rst/busy",   32'(busy14),   32'd0);
        check("rst/done",   32'(done14),   32'd0);
        check("rst/err",    32'(err14),    32'd0);
        check("rst/ovf",    32'(ovf14),    32'd0);
        check("rst/busy8",  32'(busy8),    32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Convert the largest valid operand.
        run_conv(1'b0, 16'h9999, "max9999");
        @(negedge clk);

        // A start raised during DONE must be ignored.
        run_conv(1'b0, 16'h0255, "v255");
        bcd     = 16'h0000;
        start14 = 1'b1;
        @(negedge clk);
        check("done_start_ignored/busy", 32'(busy14), 32'd0);
        check("done_start_ignored/done", 32'(done14), 32'd0);
        start14 = 1'b0;
        run_conv(1'b0, 16'h0000, "v0");
        @(negedge clk);

        // An invalid digit, followed by a valid operand.
        run_conv(1'b0, 16'h00A5, "bad_00A5");
        @(negedge clk);
        run_conv(1'b0, 16'h0001, "v1_after_err");
        @(negedge clk);

        // Use the narrow instance to exercise overflow.
        run_conv(1'b1, 16'h0300, "w8_300");
        @(negedge clk);
        run_conv(1'b1, 16'h0255, "w8_255");
        @(negedge clk);

        // Assert reset in the middle of a conversion.
        bcd     = 16'h9876;
        start14 = 1'b1;
        @(negedge clk);
        start14 = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst/binary", 32'(binary14), 32'd0);
        check("midrst/busy",   32'(busy14),   32'd0);
        check("midrst/done",   32'(done14),   32'd0);
        check("midrst/err",    32'(err14),    32'd0);
        check("midrst/ovf",    32'(ovf14),    32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done14) done_seen++;
        end
        check("midrst/no_done", 32'(done_seen), 32'd0);
        run_conv(1'b0, 16'h1234, "v1234");
        @(negedge clk);

        // Hold start high and check accept spacing and captured values.
        for (int cyc = 0; cyc < 120; cyc++) begin
            bcd     = rand_bcd();
            start14 = (cyc < 100);
            if (cyc < 100 && (cyc % 16) == 0) exp_q.push_back(dec_value(bcd));
            @(negedge clk);
            exp_done = (cyc >= 14) && (((cyc - 14) % 16) == 0) && ((cyc - 14) < 100);
            check($sformatf("stream/done@%0d", cyc), 32'(done14), 32'(exp_done));
            if (exp_done) begin
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                check($sformatf("stream/binary@%0d", cyc), 32'(binary14), 32'(exp_v));
                check($sformatf("stream/err@%0d", cyc), 32'(err14), 32'd0);
            end
        end
        start14 = 1'b0;
        check("stream/all_results", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
